vlg_sonar_ctrl: RTL and testbench
=================================

Name: vlg_sonar_ctrl

Overview:
Measurement sequencer for the ultrasonic ranging path.
- Issues the sensor trigger pulse and times the echo pulse in microseconds.
- Presents the echo time to the distance calculator (s = 709*t >> 12 mm) and captures its result after the calculator's fixed pipeline latency.
- Repeats measurements at a fixed period while enabled. Reports timeouts separately.

Parameters:
CLK_FREQ_MHZ, 25, system clock in MHz; sets the 1 us tick prescaler
TRIG_US, 10, trigger pulse width in us
PERIOD_US, 60000, trigger-to-trigger period in us (20-bit counter)
TIMEOUT_US, 38000, echo wait/high limit in us (must be < 65535)
CALC_LAT, 1, calculator latency in clocks from o_t_us change to valid i_s_mm

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  level; high = continuous measurement
i_echo  in  1  sensor echo, asynchronous, double-flop synchronised internally
i_s_mm  in  14  distance from calculator
o_trig  out  1  sensor trigger
o_t_us  out  16  echo time to calculator, held between measurements
o_dist_mm  out  14  last valid distance, held
o_dist_vld  out  1  one-clock pulse when o_dist_mm updates
o_timeout  out  1  one-clock pulse on echo timeout
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): FSM to IDLE; all counters, o_trig, o_t_us, o_dist_mm, o_dist_vld, o_timeout, o_busy cleared to 0; synchroniser flops cleared.
- us tick: prescaler counts 0..CLK_FREQ_MHZ-1 and asserts a tick on terminal count. Prescaler restarts at 0 on every state entry.
- IDLE: if i_en = 1, go to TRIG next clock.
- TRIG: o_trig = 1 for exactly TRIG_US ticks. Period counter cleared on entry and counts ticks from then on. Go to WAIT_H.
- WAIT_H: wait for a synchronised echo rising edge (prev = 0, cur = 1).
  - An echo already high on entry does not qualify.
  - If wait reaches TIMEOUT_US ticks: pulse o_timeout, go to GAP.
  - On rising edge: clear the us counter, go to MEAS.
- MEAS: count ticks while echo is high.
  - On synchronised falling edge: o_t_us <= count, go to CALC.
  - If count reaches TIMEOUT_US with no falling edge: pulse o_timeout, leave o_t_us unchanged, go to GAP.
  - A falling edge in the same clock as the count reaching TIMEOUT_US wins: the result is valid with t = TIMEOUT_US.
- CALC: wait CALC_LAT clocks after o_t_us is loaded, then:
  - o_dist_mm <= i_s_mm (or the averaged value, see Optional Feature);
  - o_dist_vld = 1 for one clock;
  - go to GAP.
- GAP: wait until the period counter reaches PERIOD_US. Then go to TRIG if i_en = 1, else IDLE. If the period counter has already expired on entry, leave on the next clock.
- i_en deasserted mid-measurement: the current measurement completes normally; the FSM then returns to IDLE via GAP.
- Echo latency: the 2-cycle synchroniser delay applies to both edges and cancels in the measured width. Resolution is ±1 us.
- o_timeout and o_dist_vld are never high together.
- A timeout leaves o_dist_mm unchanged.

Optional Feature:
Macro: VLG_SONAR_AVG4_EN
- Defined:
  - The four most recent valid i_s_mm samples are kept in a shift buffer. The buffer is cleared at reset and is not written on timeouts.
  - Output is o_dist_mm = (sum of 4) >> 2, using a 16-bit sum, truncating.
  - Until 4 valid samples exist since reset, o_dist_mm = the raw sample.
  - The average is registered. o_dist_vld then follows CALC completion by 1 extra clock.
- Not defined: o_dist_mm = raw i_s_mm; no buffer hardware.

Test Plan:
Common setup:
- Parameters CLK_FREQ_MHZ=25, TRIG_US=10, PERIOD_US=2000, TIMEOUT_US=1000, CALC_LAT=1.
- Behavioural calculator model with 1-clock latency.

1. i_en=1, echo rises 100 us after the trigger ends, echo high 580 us -> o_trig high 250 clocks; o_t_us = 580 (±1); o_dist_mm = 100; one o_dist_vld pulse; o_timeout stays 0.
2. i_en=1, echo never rises -> o_timeout pulse 1000 us after WAIT_H entry; o_dist_mm keeps its previous value; next o_trig rising edge is 2000 us after the previous one.
3. Echo held high > 1000 us -> o_timeout pulse at count 1000; o_t_us unchanged; no o_dist_vld. Echo high on WAIT_H entry of the next cycle -> no false measurement.
4. i_en dropped during MEAS (echo 580 us) -> distance 100 is still reported; FSM reaches IDLE after the period expires; no further trigger; o_busy=0.
5. Assert i_rst_n low mid-TRIG -> o_trig, o_busy and all outputs go to 0 immediately, without waiting for a clock edge; after release with i_en=1, a new full 10 us trigger is issued.
6. VLG_SONAR_AVG4_EN defined; echo widths giving raw distances 100, 100, 100, 104 -> outputs 100, 100, 100, 101; a following timeout leaves the output at 101.

Source files
------------

// File: rtl/vlg_sonar_ctrl.sv
// Ultrasonic ranging sequencer: trigger, echo timing in us, distance capture, periodic repeat.
// Optional 4-sample distance averaging is enabled by defining VLG_SONAR_AVG4_EN.
module vlg_sonar_ctrl #(
  parameter int CLK_FREQ_MHZ = 25,
  parameter int TRIG_US      = 10,
  parameter int PERIOD_US    = 60000,
  parameter int TIMEOUT_US   = 38000,
  parameter int CALC_LAT     = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic        i_echo,
  input  logic [13:0] i_s_mm,
  output logic        o_trig,
  output logic [15:0] o_t_us,
  output logic [13:0] o_dist_mm,
  output logic        o_dist_vld,
  output logic        o_timeout,
  output logic        o_busy
);

  // state  | meaning
  // IDLE   | disabled, waiting for i_en
  // TRIG   | driving the trigger pulse, period counter restarted
  // WAIT_H | waiting for the echo rising edge
  // MEAS   | timing the echo high phase
  // CALC   | waiting for the calculator pipeline
  // GAP    | waiting out the rest of the measurement period
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_H, MEAS, CALC, GAP} state_t;

  localparam int            PW      = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [PW-1:0] PRE_TC  = PW'(CLK_FREQ_MHZ - 1);
  localparam logic [15:0]   TRIG_TC = 16'(TRIG_US - 1);
  localparam logic [15:0]   TO_TC   = 16'(TIMEOUT_US - 1);
  localparam logic [15:0]   CALC_TC = 16'(CALC_LAT);
  localparam logic [19:0]   PER_END = 20'(PERIOD_US);
  localparam logic [19:0]   PER_TC  = 20'(PERIOD_US - 1);

  state_t        state, state_nxt;
  logic [PW-1:0] pre_cnt;
  logic [15:0]   us_cnt;
  logic [19:0]   per_cnt;
  logic          echo_s1, echo_s2, echo_prev;
  logic          tick, entry, rise, fall, per_done;
  logic          to_set, load_t, cap;

  assign tick     = (pre_cnt == PRE_TC);
  assign entry    = (state_nxt != state);
  assign rise     = echo_s2 & ~echo_prev;
  assign fall     = ~echo_s2 & echo_prev;
  assign per_done = (per_cnt == PER_END) || (tick && (per_cnt == PER_TC));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      echo_s1   <= 1'b0;
      echo_s2   <= 1'b0;
      echo_prev <= 1'b0;
    end else begin
      state     <= state_nxt;
      echo_s1   <= i_echo;
      echo_s2   <= echo_s1;
      echo_prev <= echo_s2;
    end
  end

  always_comb begin
    state_nxt = state;
    to_set    = 1'b0;
    load_t    = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE:   if (i_en) state_nxt = TRIG;
      TRIG:   if (tick && (us_cnt == TRIG_TC)) state_nxt = WAIT_H;
      WAIT_H: begin
        if (rise) begin
          state_nxt = MEAS;
        end else if (tick && (us_cnt == TO_TC)) begin
          to_set    = 1'b1;
          state_nxt = GAP;
        end
      end
      // a falling edge takes priority over the timeout in the same clock
      MEAS: begin
        if (fall) begin
          load_t    = 1'b1;
          state_nxt = CALC;
        end else if (tick && (us_cnt == TO_TC)) begin
          to_set    = 1'b1;
          state_nxt = GAP;
        end
      end
      CALC: begin
        if (us_cnt == CALC_TC) begin
          cap       = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP:     if (per_done) state_nxt = i_en ? TRIG : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // us counter: trigger width, echo wait, echo width, and clocks in CALC
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_cnt <= '0;
      us_cnt  <= '0;
      per_cnt <= '0;
    end else begin
      pre_cnt <= (entry || tick) ? '0 : pre_cnt + 1'b1;
      if (entry) begin
        us_cnt <= '0;
      end else begin
        case (state)
          TRIG, WAIT_H, MEAS: if (tick) us_cnt <= us_cnt + 16'd1;
          CALC:               us_cnt <= us_cnt + 16'd1;
          default:            us_cnt <= us_cnt;
        endcase
      end
      if (state_nxt == TRIG && state != TRIG) per_cnt <= '0;
      else if (tick && (per_cnt != PER_END))  per_cnt <= per_cnt + 20'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_trig    <= 1'b0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
      o_t_us    <= '0;
    end else begin
      o_trig    <= (state_nxt == TRIG);
      o_busy    <= (state_nxt != IDLE);
      o_timeout <= to_set;
      if (load_t) o_t_us <= us_cnt + 16'(tick);
    end
  end

`ifdef VLG_SONAR_AVG4_EN
  logic [3:0][13:0] smp;
  logic [2:0]       n_smp;
  logic             avg_pend;
  logic [15:0]      sum4;

  assign sum4 = 16'(smp[0]) + 16'(smp[1]) + 16'(smp[2]) + 16'(smp[3]);

  // average is registered one clock after capture, so the valid pulse trails CALC by one clock
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      smp        <= '0;
      n_smp      <= '0;
      avg_pend   <= 1'b0;
      o_dist_mm  <= '0;
      o_dist_vld <= 1'b0;
    end else begin
      avg_pend   <= cap;
      o_dist_vld <= avg_pend;
      if (cap) begin
        smp <= {smp[2:0], i_s_mm};
        if (n_smp != 3'd4) n_smp <= n_smp + 3'd1;
      end
      if (avg_pend) o_dist_mm <= (n_smp == 3'd4) ? sum4[15:2] : smp[0];
    end
  end
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dist_mm  <= '0;
      o_dist_vld <= 1'b0;
    end else begin
      o_dist_vld <= cap;
      if (cap) o_dist_mm <= i_s_mm;
    end
  end
`endif

endmodule

// File: tb/tb_vlg_sonar_ctrl.sv
// Directed bench for vlg_sonar_ctrl with a behavioural 1-clock distance calculator.
// The clock prescaler is set to 2 clocks/us so full 2000 us periods stay short.
module tb_vlg_sonar_ctrl;
  localparam int US = 2;
`ifdef VLG_SONAR_AVG4_EN
  localparam int EXP_D4 = 101;
`else
  localparam int EXP_D4 = 104;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, echo = 1'b0;
  logic [13:0] s_mm = '0;
  logic        o_trig, o_dist_vld, o_timeout, o_busy;
  logic [15:0] o_t_us;
  logic [13:0] o_dist_mm;

  vlg_sonar_ctrl #(
    .CLK_FREQ_MHZ(US), .TRIG_US(10), .PERIOD_US(2000), .TIMEOUT_US(1000), .CALC_LAT(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_echo(echo), .i_s_mm(s_mm),
    .o_trig(o_trig), .o_t_us(o_t_us), .o_dist_mm(o_dist_mm), .o_dist_vld(o_dist_vld),
    .o_timeout(o_timeout), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) s_mm <= 14'((32'd709 * 32'(o_t_us)) >> 12);

  int n_assert = 0, n_fail = 0;
  int n_vld = 0, n_to = 0, n_both = 0, n_rise = 0, trig_len = 0, cyc = 0;
  int rise_prev = 0, rise_last = 0;
  logic trig_d = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (o_dist_vld) n_vld++;
    if (o_timeout) n_to++;
    if (o_dist_vld && o_timeout) n_both++;
    if (o_trig && !trig_d) begin
      n_rise++;
      rise_prev = rise_last;
      rise_last = cyc;
      trig_len  = 0;
    end
    if (o_trig) trig_len++;
    trig_d = o_trig;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sel_val(input int sel);
    case (sel)
      0:       return o_trig;
      1:       return !o_trig;
      2:       return o_dist_vld;
      3:       return o_timeout;
      default: return !o_busy;
    endcase
  endfunction

  // sel: 0 trig high, 1 trig low, 2 dist valid, 3 timeout, 4 not busy
  task automatic wait_on(input int sel, input int max, input string tag, output int n);
    n = 0;
    while (n < max && sel_val(sel) !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(sel_val(sel)), 1);
    #1;
  endtask

  task automatic pulse_echo(input int delay_us, input int width_us);
    repeat (delay_us * US) @(negedge clk);
    echo = 1'b1;
    repeat (width_us * US) @(negedge clk);
    echo = 1'b0;
  endtask

  int n, v0, to0, r0;
  logic [15:0] t_prev;
  int w6[4] = '{580, 580, 580, 603};
  int e6[4] = '{100, 100, 100, EXP_D4};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_trig", 32'(o_trig), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_t_us", 32'(o_t_us), 0);
    chk("rst_dist", 32'(o_dist_mm), 0);
    chk("rst_vld_to", 32'({o_dist_vld, o_timeout}), 0);
    rst_n = 1'b1;
    en    = 1'b1;

    // 1: normal 580 us echo
    wait_on(0, 10, "t1_trig_rise", n);
    wait_on(1, 100, "t1_trig_fall", n);
    chk("t1_trig_len", 32'(trig_len), 10 * US);
    pulse_echo(100, 580);
    wait_on(2, 100, "t1_vld", n);
    chk("t1_dist", 32'(o_dist_mm), 100);
    chk("t1_t_us", 32'(o_t_us >= 16'd579 && o_t_us <= 16'd581), 1);
    repeat (3) @(negedge clk);
    #1;
    chk("t1_n_vld", 32'(n_vld), 1);
    chk("t1_n_to", 32'(n_to), 0);
    t_prev = o_t_us;

    // 2: no echo at all
    wait_on(0, 5000, "t2_trig_rise", n);
    wait_on(1, 100, "t2_trig_fall", n);
    wait_on(3, 2100, "t2_timeout", n);
    chk("t2_to_delay", 32'(n), 1000 * US);
    chk("t2_dist_kept", 32'(o_dist_mm), 100);
    wait_on(0, 5000, "t2_next_trig", n);
    chk("t2_period", 32'(rise_last - rise_prev), 2000 * US);

    // 3: echo stuck high through this and the next measurement
    v0 = n_vld;
    wait_on(1, 100, "t3_trig_fall", n);
    repeat (50 * US) @(negedge clk);
    echo = 1'b1;
    wait_on(3, 2100, "t3_meas_to", n);
    chk("t3_to_delay", 32'(n >= 1000 * US + 2 && n <= 1000 * US + 4), 1);
    chk("t3_t_us_kept", 32'(o_t_us), 32'(t_prev));
    wait_on(0, 5000, "t3_trig_rise", n);
    wait_on(1, 100, "t3_trig_fall", n);
    wait_on(3, 2100, "t3_wait_to", n);
    chk("t3_wait_to_delay", 32'(n), 1000 * US);
    echo = 1'b0;
    chk("t3_no_vld", 32'(n_vld), 32'(v0));
    chk("t3_dist_kept", 32'(o_dist_mm), 100);

    // 4: enable dropped during MEAS
    wait_on(0, 5000, "t4_trig_rise", n);
    wait_on(1, 100, "t4_trig_fall", n);
    v0 = n_vld;
    repeat (100 * US) @(negedge clk);
    echo = 1'b1;
    repeat (200 * US) @(negedge clk);
    en = 1'b0;
    repeat (380 * US) @(negedge clk);
    echo = 1'b0;
    wait_on(2, 100, "t4_vld", n);
    chk("t4_dist", 32'(o_dist_mm), 100);
    wait_on(4, 5000, "t4_idle", n);
    r0 = n_rise;
    repeat (2500 * US) @(negedge clk);
    chk("t4_no_trig", 32'(n_rise), 32'(r0));
    chk("t4_busy", 32'(o_busy), 0);
    chk("t4_one_vld", 32'(n_vld - v0), 1);

    // 5: async reset mid-trigger
    en = 1'b1;
    wait_on(0, 10, "t5_trig_rise", n);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_trig", 32'(o_trig), 0);
    chk("t5_busy", 32'(o_busy), 0);
    chk("t5_dist", 32'(o_dist_mm), 0);
    chk("t5_t_us", 32'(o_t_us), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_on(0, 10, "t5_trig_rise2", n);
    wait_on(1, 100, "t5_trig_fall2", n);
    chk("t5_trig_len", 32'(trig_len), 10 * US);

    // 6: four samples after reset, then a timeout
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        wait_on(0, 5000, "t6_trig_rise", n);
        wait_on(1, 100, "t6_trig_fall", n);
      end
      pulse_echo(50, w6[k]);
      wait_on(2, 100, "t6_vld", n);
      chk($sformatf("t6_dist%0d", k), 32'(o_dist_mm), 32'(e6[k]));
    end
    to0 = n_to;
    wait_on(0, 5000, "t6_trig_rise_to", n);
    wait_on(1, 100, "t6_trig_fall_to", n);
    wait_on(3, 2100, "t6_timeout", n);
    chk("t6_dist_kept", 32'(o_dist_mm), 32'(EXP_D4));
    chk("t6_n_to", 32'(n_to - to0), 1);
    chk("never_both", 32'(n_both), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
